muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 start  input  1  request strobe; sampled only in IDLE.
REQ-004 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 rs1_val  input  32  operand A (dividend / multiplicand), driven from register-file read port 1.
REQ-006 rs2_val  input  32  operand B (divisor / multiplier), driven from register-file read port 2.
REQ-007 rd  input  5  destination register index.
REQ-008 busy  output  1  high whenever state != IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 wb_en  output  1  register-file write enable; equals done AND (wb_addr != 0).
REQ-011 wb_addr  output  5  latched rd, feeds register-file write address.
REQ-012 wb_data  output  32  result, feeds register-file write data.

Function
REQ-013 FSM states SHALL be IDLE, MUL, DIV, DONE.
REQ-014 IDLE with start=1 at edge E0: latch funct3, rs1_val, rs2_val, rd; go to MUL if funct3[2]=0, else DIV.
REQ-015 start while busy=1 SHALL be ignored; latched operands SHALL NOT change until the unit returns to IDLE.
REQ-016 MUL: at E1 register the 64-bit product; go to DONE.
REQ-017 MUL/MULHU: unsigned x unsigned; MULH: signed x signed; MULHSU: signed rs1 x unsigned rs2; MUL returns product[31:0], others return product[63:32].
REQ-018 DIV: restoring or non-restoring radix-2 on operand magnitudes, one quotient bit per cycle, 32 iterations at E1..E32; go to DONE after E32.
REQ-019 Signed ops (DIV, REM): quotient negated when operand signs differ; remainder takes the sign of the dividend.
REQ-020 Divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU), remainder = rs1_val; SHALL go directly to DONE at E1.
REQ-021 Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM only): quotient = 0x80000000, remainder = 0; SHALL go directly to DONE at E1.
REQ-022 DONE lasts exactly one cycle: done=1, wb_data valid, wb_en per REQ-010; next edge returns to IDLE.
REQ-023 Latency from the start edge: multiply and special-case divide SHALL assert done in the cycle after E1 (2 cycles); normal divide SHALL assert done in the cycle after E32 (33 cycles).
REQ-024 A start asserted in the cycle in which done=1 SHALL be ignored; the earliest accepted restart is the following cycle.
REQ-025 wb_data and wb_addr SHALL hold their last values until the next completion.
REQ-026 rd=0 SHALL complete normally with done=1 and wb_en=0.

Reset
REQ-027 rst=1 SHALL immediately force IDLE and drive busy=0, done=0, wb_en=0, wb_addr=0, wb_data=0, with all internal registers cleared.
REQ-028 rst asserted mid-operation SHALL abort the operation with no writeback; the first start after rst deasserts SHALL be accepted normally.

Verification
REQ-029 MUL rs1=0xFFFFFFFF rs2=0x00000002 rd=5 -> done 2 cycles later, wb_data=0xFFFFFFFE, wb_en=1, wb_addr=5; MULHU with the same operands -> 0x00000001; MULH -> 0xFFFFFFFF.
REQ-030 DIV rs1=0xFFFFFFF9 (-7) rs2=2 -> done at cycle 33, wb_data=0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU -> 2.
REQ-031 DIVU 0x1234 / 0 -> done at cycle 2, wb_data=0xFFFFFFFF; REMU -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> done at cycle 2, wb_data=0x80000000; REM -> 0.
REQ-032 Start DIVU 100/7, then pulse start with changed operands on cycles 5 and 20 -> both ignored, result=14, exactly one done pulse; start held high across DONE -> next operation accepted one cycle after done.
REQ-033 Start DIV, assert rst at cycle 10 -> busy=0, done never pulses, wb_data=0; new MUL 3*4 after reset -> wb_data=12 at cycle 2.
REQ-034 MUL 3*4 with rd=0 -> done=1, wb_en=0, wb_data=12.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if -- request / writeback bundle for the RV32M multiply-divide unit.
//
// Request side (driven by the issuing stage):
//   start    1   request strobe, only honoured while the unit is idle
//   funct3   3   RV32M operation select
//   rs1_val  32  operand A (dividend / multiplicand)
//   rs2_val  32  operand B (divisor / multiplier)
//   rd       5   destination register index
// Response side (driven by the unit):
//   busy     1   unit is working on an operation
//   done     1   one-cycle completion pulse
//   wb_en    1   register-file write enable (done and wb_addr != 0)
//   wb_addr  5   destination of the last completed operation
//   wb_data  32  result of the last completed operation
interface muldiv_unit_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
    logic        busy;
    logic        done;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    modport master (
        output start, funct3, rs1_val, rs2_val, rd,
        input  busy, done, wb_en, wb_addr, wb_data
    );

    modport slave (
        input  start, funct3, rs1_val, rs2_val, rd,
        output busy, done, wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit -- RV32M multiply / divide execution unit.
//
// Multiplies complete in one working cycle (done two cycles after the start
// edge). Divides use a radix-2 restoring loop on operand magnitudes, one
// quotient bit per cycle for 32 cycles (done 33 cycles after the start edge);
// divide-by-zero and signed overflow finish after a single working cycle.
//
// Ports:
//   clk  1   clock, rising edge
//   rst  1   asynchronous active-high reset
//   bus  muldiv_unit_if.slave  request / writeback bundle
module muldiv_unit (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state_reg, state_next;

    // Operation captured at the start edge; frozen until the unit is idle again.
    logic [1:0]  funct3_reg;
    logic [31:0] rs1_reg;
    logic [31:0] rs2_reg;
    logic [4:0]  rd_reg;

    // Divider working state: quo_reg starts as |dividend| and is shifted out
    // into the partial remainder while quotient bits are shifted in.
    logic [31:0] rem_reg;
    logic [31:0] quo_reg;
    logic [31:0] dvsr_reg;
    logic [4:0]  count_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;

    logic [4:0]  wb_addr_reg;
    logic [31:0] wb_data_reg;

    // ---------------- request-side magnitude preparation ----------------
    logic        accept;
    logic        div_signed_in;
    logic        neg_a_in;
    logic        neg_b_in;
    logic [31:0] abs_a_in;
    logic [31:0] abs_b_in;

    assign accept        = (state_reg == IDLE) && bus.start;
    assign div_signed_in = ~bus.funct3[0];
    assign neg_a_in      = div_signed_in & bus.rs1_val[31];
    assign neg_b_in      = div_signed_in & bus.rs2_val[31];
    assign abs_a_in      = neg_a_in ? -bus.rs1_val : bus.rs1_val;
    assign abs_b_in      = neg_b_in ? -bus.rs2_val : bus.rs2_val;

    // ---------------- multiply ----------------
    // Each operand is widened by one bit carrying either its sign or a zero,
    // so a single signed multiplier covers MULH, MULHSU and MULHU. Only the
    // low 64 bits of the product are ever needed.
    logic        a_sgn;
    logic        b_sgn;
    logic [32:0] a_ext;
    logic [32:0] b_ext;
    logic signed [63:0] prod;
    logic [31:0] mul_res;

    assign a_sgn   = (funct3_reg == 2'b01) || (funct3_reg == 2'b10);
    assign b_sgn   = (funct3_reg == 2'b01);
    assign a_ext   = {a_sgn & rs1_reg[31], rs1_reg};
    assign b_ext   = {b_sgn & rs2_reg[31], rs2_reg};
    assign prod    = $signed(a_ext) * $signed(b_ext);
    assign mul_res = (funct3_reg == 2'b00) ? prod[31:0] : prod[63:32];

    // ---------------- divide ----------------
    logic        div_by_zero;
    logic        div_ovf;
    logic        special;
    logic [31:0] special_res;
    logic [32:0] rem_shift;
    logic [32:0] trial;
    logic        q_bit;
    logic [31:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] div_res;
    logic        last_iter;

    assign div_by_zero = (rs2_reg == 32'h0);
    assign div_ovf     = ~funct3_reg[0] && (rs1_reg == 32'h8000_0000)
                         && (rs2_reg == 32'hFFFF_FFFF);
    assign special     = div_by_zero | div_ovf;
    // funct3[1] selects remainder over quotient.
    assign special_res = funct3_reg[1] ? (div_by_zero ? rs1_reg : 32'h0)
                                       : (div_by_zero ? 32'hFFFF_FFFF : 32'h8000_0000);

    assign rem_shift = {rem_reg, quo_reg[31]};
    assign trial     = rem_shift - {1'b0, dvsr_reg};
    assign q_bit     = ~trial[32];
    assign rem_step  = q_bit ? trial[31:0] : rem_shift[31:0];
    assign quo_step  = {quo_reg[30:0], q_bit};
    assign last_iter = (count_reg == 5'd31);
    assign div_res   = funct3_reg[1] ? (neg_r_reg ? -rem_step : rem_step)
                                     : (neg_q_reg ? -quo_step : quo_step);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (bus.start) state_next = bus.funct3[2] ? DIV : MUL;
            MUL:  state_next = DONE;
            DIV:  if (special || last_iter) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct3_reg  <= 2'b00;
            rs1_reg     <= 32'h0;
            rs2_reg     <= 32'h0;
            rd_reg      <= 5'd0;
            rem_reg     <= 32'h0;
            quo_reg     <= 32'h0;
            dvsr_reg    <= 32'h0;
            count_reg   <= 5'd0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            wb_addr_reg <= 5'd0;
            wb_data_reg <= 32'h0;
        end else begin
            if (accept) begin
                funct3_reg <= bus.funct3[1:0];
                rs1_reg    <= bus.rs1_val;
                rs2_reg    <= bus.rs2_val;
                rd_reg     <= bus.rd;
                rem_reg    <= 32'h0;
                quo_reg    <= abs_a_in;
                dvsr_reg   <= abs_b_in;
                count_reg  <= 5'd0;
                neg_q_reg  <= neg_a_in ^ neg_b_in;
                neg_r_reg  <= neg_a_in;
            end
            case (state_reg)
                MUL: begin
                    wb_data_reg <= mul_res;
                    wb_addr_reg <= rd_reg;
                end
                DIV: begin
                    if (special) begin
                        wb_data_reg <= special_res;
                        wb_addr_reg <= rd_reg;
                    end else begin
                        rem_reg   <= rem_step;
                        quo_reg   <= quo_step;
                        count_reg <= count_reg + 5'd1;
                        if (last_iter) begin
                            wb_data_reg <= div_res;
                            wb_addr_reg <= rd_reg;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state_reg != IDLE);
    assign bus.done    = (state_reg == DONE);
    assign bus.wb_en   = (state_reg == DONE) && (wb_addr_reg != 5'd0);
    assign bus.wb_addr = wb_addr_reg;
    assign bus.wb_data = wb_data_reg;
endmodule
